mmio_combiner: RTL and testbench
================================

# mmio_combiner

Parametrised register-mapped combiner. NCH input FIFOs are loaded over a write port, and a programmable op (OR/AND/XOR/ADD) reduces their heads into an output FIFO. A combine fires only when every input is non-empty, the output has room, and a programmable period timer hits. The output is drained and status is read over a read port. It is the next generation of the fixed two-input, fixed-period OR test DUT, and sits as a cocotb-facing bench target behind the same write/read port style.

## Interface
- WIDTH, 8: data width; must be ≥ 8
- NCH, 2: input channels, 2..8
- DEPTH, 2: entries per input FIFO, power of two, ≥ 2
- ODEPTH, 4: output FIFO entries, power of two, ≥ 2

- CLK  in  1  clock
- RST_N  in  1  reset, synchronous, active-low
- write_address  in  4  write target
- write_data  in  WIDTH  write payload
- write_en  in  1  write strobe
- write_rdy  out  1  constant 1
- read_address  in  4  read target
- read_en  in  1  read strobe; pops only at the OUT address
- read_data  out  WIDTH  combinational read mux
- read_rdy  out  1  constant 1
- fire  out  1  registered; 1-cycle pulse, the cycle after each combine

## Operation
Write map (addresses from package):
- 0..NCH-1: enqueue write_data into channel i.
  - If channel i is full before the edge, the write is dropped and drop_cnt increments (saturating at 2^WIDTH-1).
- 8 CFG_MODE: mode ← write_data[1:0]; 0 OR, 1 AND, 2 XOR, 3 ADD (mod 2^WIDTH).
- 9 CFG_PERIOD: period ← write_data[7:0]; tick counter ← 0.
- 10 CLR_DROPS: drop_cnt ← 0.
- Any other address is ignored.

Read map:
- 0..NCH-1: head of channel i, no pop; 0 if empty.
- 8 STATUS: bit0 out non-empty, bit1 out full, bit2 all inputs non-empty, bits[7:3]=0.
- 9 OUT: head of the output FIFO; 0 if empty. With read_en and non-empty, pops at the edge.
- 10 DROPS: drop_cnt.
- 11 LEVEL: output FIFO occupancy.
- 12 PERIOD: period.
- Other addresses read 0.

Timer:
- 8-bit tick counter, free-running, range 0..period.
- At period it wraps to 0 on the next edge.
- tick = (counter == period). Period 0 means tick every cycle.

Combine:
- fire_now = tick & all inputs non-empty & output not full, all evaluated before the edge.
- On fire_now: pop every input, push the reduced value into the output, and assert fire for the next cycle.

## Timing
- Reset state: all FIFOs empty, mode=0, period=50, counter=0, drop_cnt=0, fire=0. read_data reflects the reset state (e.g. STATUS=0).
- Enqueue to an empty channel: the value is visible at its read address and eligible to fire the cycle after the edge.
- Output pop latency: read_data at OUT is valid in the same cycle as read_en; the pop takes effect at that edge.
- Full output plus a simultaneous pop and fire_now: fire is blocked for that cycle, and the data stays in the inputs.
- Full input plus a simultaneous enqueue and fire pop: the enqueue is dropped, because full is checked before the edge.
- Input enqueue and combine pop on a non-full channel in the same cycle: both occur; occupancy is unchanged.
- Output FIFO pop and push in the same cycle: both occur; occupancy is unchanged.
- CFG_PERIOD write coincident with a tick: the combine still uses the old tick, and the counter restarts at 0.
- Reset asserted mid-operation: all state returns to the reset values at the next edge, and pending data is lost.

## Structure
- Package mmio_combiner_pkg holds:
  - address localparams A_CFG_MODE=8, A_CFG_PERIOD=9, A_CLR_DROPS=10, A_STATUS=8, A_OUT=9, A_DROPS=10, A_LEVEL=11, A_PERIOD=12;
  - the op enum op_e {OP_OR, OP_AND, OP_XOR, OP_ADD};
  - PERIOD_RST=50.
- One sub-module, sync_fifo: parameters WIDTH and DEPTH; ports enq, deq, din, dout, full, empty, count; synchronous reset.
  - Instantiate it NCH times for the inputs (generate loop) and once with ODEPTH for the output.
- The reduction is a combinational loop over the channel heads, selected by mode.

## Test plan
- Reset, then write 0x0F to ch0 and 0xF0 to ch1 with default period 50 and mode OR → fire only when counter==50; OUT reads 0xFF; STATUS then reads 0x01.
- Period=0, mode ADD, NCH=2, write 0xC8 and 0x64 → OUT=0x2C the cycle after fire; LEVEL=1; a pop returns LEVEL=0.
- Period=0, fill ch0 with DEPTH+1 writes and ch1 empty → drop_cnt=1, no fire; CLR_DROPS → DROPS reads 0.
- Period=0, no reads, 5 paired writes with ODEPTH=4 → 4 combines, STATUS bit1=1, and the 5th pair is held in the inputs. One pop leads to a combine the following cycle, not the same cycle.
- Mode XOR, period=3: write pairs back-to-back → fire pulses spaced exactly 4 cycles apart.
- Assert RST_N=0 for one cycle with data in every FIFO → next cycle STATUS=0, DROPS=0, PERIOD=50, ch heads read 0.

Source files
------------

// File: rtl/mmio_combiner_pkg.sv
// rtl/mmio_combiner_pkg.sv - register map, op encoding and reset constants for mmio_combiner
package mmio_combiner_pkg;

  // Write map (channel enqueue addresses are 0..NCH-1)
  localparam logic [3:0] A_CFG_MODE   = 4'd8;
  localparam logic [3:0] A_CFG_PERIOD = 4'd9;
  localparam logic [3:0] A_CLR_DROPS  = 4'd10;

  // Read map (channel head addresses are 0..NCH-1)
  localparam logic [3:0] A_STATUS     = 4'd8;
  localparam logic [3:0] A_OUT        = 4'd9;
  localparam logic [3:0] A_DROPS      = 4'd10;
  localparam logic [3:0] A_LEVEL      = 4'd11;
  localparam logic [3:0] A_PERIOD     = 4'd12;

  localparam logic [7:0] PERIOD_RST   = 8'd50;

  typedef enum logic [1:0] {
    OP_OR  = 2'd0,
    OP_AND = 2'd1,
    OP_XOR = 2'd2,
    OP_ADD = 2'd3
  } op_e;

endpackage

// File: rtl/mmio_combiner_sync_fifo.sv
// rtl/mmio_combiner_sync_fifo.sv - power-of-two synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     enq,
  input  logic                     deq,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_enq, do_deq;

  assign full   = (cnt_q == (AW+1)'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign count  = cnt_q;
  assign dout   = mem_q[rd_q];
  assign do_enq = enq && !full;
  assign do_deq = deq && !empty;

  always_comb begin
    wr_d  = do_enq ? wr_q + AW'(1) : wr_q;
    rd_d  = do_deq ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(do_enq) - (AW+1)'(do_deq);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: the count gates every read of stale entries.
  always_ff @(posedge CLK) begin
    if (do_enq) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/mmio_combiner.sv
// rtl/mmio_combiner.sv - NCH input FIFOs reduced by a programmable op into an output FIFO
// on a programmable period tick; write port loads/configures, read port drains/observes.
module mmio_combiner
  import mmio_combiner_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCH    = 2,
  parameter int DEPTH  = 2,
  parameter int ODEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_en,
  output logic             write_rdy,
  input  logic [3:0]       read_address,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             read_rdy,
  output logic             fire
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int OCW = $clog2(ODEPTH) + 1;

  logic [NCH-1:0][WIDTH-1:0] in_head;
  logic [NCH-1:0][CW-1:0]    in_count;
  logic [NCH-1:0]            in_full, in_empty, ch_sel, in_enq;

  logic [WIDTH-1:0]          out_head;
  logic [OCW-1:0]            out_count;
  logic                      out_full, out_empty, out_deq;

  logic                      all_ne, tick, fire_now;
  logic [WIDTH-1:0]          reduced;

  op_e                       mode_q, mode_d;
  logic [7:0]                period_q, period_d, cnt_q, cnt_d;
  logic [WIDTH-1:0]          drop_q, drop_d;
  logic                      fire_q;

  assign write_rdy = 1'b1;
  assign read_rdy  = 1'b1;
  assign fire      = fire_q;

  always_comb begin
    all_ne = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      ch_sel[i] = write_en && (write_address == 4'(i));
      all_ne    = all_ne && (in_count[i] != '0);
    end
  end

  // Full is sampled before the edge, so a simultaneous combine pop cannot rescue a write.
  assign in_enq   = ch_sel & ~in_full;
  assign tick     = (cnt_q == period_q);
  assign fire_now = tick && all_ne && !out_full;
  assign out_deq  = read_en && (read_address == A_OUT) && !out_empty;

  for (genvar g = 0; g < NCH; g++) begin : g_in
    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .CLK   (CLK),
      .RST_N (RST_N),
      .enq   (in_enq[g]),
      .deq   (fire_now),
      .din   (write_data),
      .dout  (in_head[g]),
      .full  (in_full[g]),
      .empty (in_empty[g]),
      .count (in_count[g])
    );
  end

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(ODEPTH)) u_out (
    .CLK   (CLK),
    .RST_N (RST_N),
    .enq   (fire_now),
    .deq   (out_deq),
    .din   (reduced),
    .dout  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  always_comb begin
    reduced = in_head[0];
    for (int i = 1; i < NCH; i++) begin
      case (mode_q)
        OP_OR:   reduced = reduced | in_head[i];
        OP_AND:  reduced = reduced & in_head[i];
        OP_XOR:  reduced = reduced ^ in_head[i];
        default: reduced = reduced + in_head[i];
      endcase
    end
  end

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    drop_d   = drop_q;
    cnt_d    = tick ? 8'd0 : cnt_q + 8'd1;
    if (|(ch_sel & in_full) && (drop_q != '1)) drop_d = drop_q + WIDTH'(1);
    if (write_en) begin
      case (write_address)
        A_CFG_MODE:   mode_d = op_e'(write_data[1:0]);
        A_CFG_PERIOD: begin
          period_d = write_data[7:0];
          cnt_d    = 8'd0;
        end
        A_CLR_DROPS:  drop_d = '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mode_q   <= OP_OR;
      period_q <= PERIOD_RST;
      cnt_q    <= 8'd0;
      drop_q   <= '0;
      fire_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      fire_q   <= fire_now;
    end
  end

  always_comb begin
    read_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if ((read_address == 4'(i)) && !in_empty[i]) read_data = in_head[i];
    end
    case (read_address)
      A_STATUS: read_data = WIDTH'({all_ne, out_full, !out_empty});
      A_OUT:    if (!out_empty) read_data = out_head;
      A_DROPS:  read_data = drop_q;
      A_LEVEL:  read_data = WIDTH'(out_count);
      A_PERIOD: read_data = WIDTH'(period_q);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mmio_combiner.sv
// tb/tb_mmio_combiner.sv - directed and random stimulus for mmio_combiner against a queue model
module tb_mmio_combiner;

  localparam int WIDTH  = 8;
  localparam int NCH    = 2;
  localparam int DEPTH  = 2;
  localparam int ODEPTH = 4;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [3:0]       write_address;
  logic [WIDTH-1:0] write_data;
  logic             write_en;
  logic             write_rdy;
  logic [3:0]       read_address;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             read_rdy;
  logic             fire;

  mmio_combiner #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH(DEPTH), .ODEPTH(ODEPTH)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .write_address (write_address),
    .write_data    (write_data),
    .write_en      (write_en),
    .write_rdy     (write_rdy),
    .read_address  (read_address),
    .read_en       (read_en),
    .read_data     (read_data),
    .read_rdy      (read_rdy),
    .fire          (fire)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [7:0] inbuf [NCH][DEPTH];
  int         incnt [NCH];
  logic [7:0] outq [$];
  int         m_mode, m_period, m_cnt, m_drops;
  logic       m_fire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_all_ne();
    logic r = 1'b1;
    for (int i = 0; i < NCH; i++) if (incnt[i] == 0) r = 1'b0;
    return r;
  endfunction

  function automatic logic [7:0] m_reduce();
    int acc = int'(inbuf[0][0]);
    for (int i = 1; i < NCH; i++) begin
      case (m_mode)
        0: acc = acc | int'(inbuf[i][0]);
        1: acc = acc & int'(inbuf[i][0]);
        2: acc = acc ^ int'(inbuf[i][0]);
        default: acc = (acc + int'(inbuf[i][0])) % 256;
      endcase
    end
    return 8'(acc);
  endfunction

  function automatic logic [7:0] m_read(input int a);
    logic [7:0] v = 8'h00;
    if (a < NCH) v = (incnt[a] > 0) ? inbuf[a][0] : 8'h00;
    else if (a == 8) v = {5'b0, m_all_ne(), outq.size() == ODEPTH, outq.size() > 0};
    else if (a == 9) v = (outq.size() > 0) ? outq[0] : 8'h00;
    else if (a == 10) v = 8'(m_drops);
    else if (a == 11) v = 8'(outq.size());
    else if (a == 12) v = 8'(m_period);
    return v;
  endfunction

  task automatic m_edge(input logic we, input int wa, input logic [7:0] wd,
                        input logic re, input int ra, input logic rst_n);
    logic       tk, fn;
    logic [7:0] v;
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) incnt[i] = 0;
      outq.delete();
      m_mode = 0; m_period = 50; m_cnt = 0; m_drops = 0; m_fire = 1'b0;
    end else begin
      tk = (m_cnt == m_period);
      fn = tk && m_all_ne() && (outq.size() < ODEPTH);
      v  = m_reduce();
      if (re && ra == 9 && outq.size() > 0) void'(outq.pop_front());
      if (we && wa < NCH) begin
        if (incnt[wa] == DEPTH) begin
          if (m_drops < 255) m_drops++;
        end else begin
          inbuf[wa][incnt[wa]] = wd;
          incnt[wa]++;
        end
      end
      if (fn) begin
        for (int i = 0; i < NCH; i++) begin
          for (int j = 1; j < DEPTH; j++) inbuf[i][j-1] = inbuf[i][j];
          incnt[i]--;
        end
        outq.push_back(v);
      end
      m_cnt = tk ? 0 : m_cnt + 1;
      if (we && wa == 8) m_mode = int'(wd[1:0]);
      if (we && wa == 9) begin m_period = int'(wd); m_cnt = 0; end
      if (we && wa == 10) m_drops = 0;
      m_fire = fn;
    end
  endtask

  // One clock: drive, check pre-edge read_data, advance model and DUT, check fire.
  task automatic step(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic re, input logic [3:0] ra, input logic rst_n,
                      output logic [7:0] rd);
    write_en = we; write_address = wa; write_data = wd;
    read_en = re; read_address = ra; RST_N = rst_n;
    #1;
    rd = read_data;
    chk($sformatf("read_data@%0d", ra), 32'(read_data), 32'(m_read(int'(ra))));
    m_edge(we, int'(wa), wd, re, int'(ra), rst_n);
    @(posedge CLK);
    #1;
    chk("fire", 32'(fire), 32'(m_fire));
    @(negedge CLK);
  endtask

  logic [7:0] rd;

  task automatic drain();
    for (int k = 0; k < 16; k++) begin
      if (outq.size() == 0 && !m_all_ne()) break;
      step(1'b0, 4'd0, 8'd0, 1'b1, 4'd9, 1'b1, rd);
    end
  endtask

  initial begin
    int n, nf, last;
    logic [3:0] wa;
    logic [7:0] wd;

    RST_N = 1'b0; write_en = 1'b0; write_address = '0; write_data = '0;
    read_en = 1'b0; read_address = '0;
    m_edge(1'b0, 0, 8'd0, 1'b0, 0, 1'b0);
    @(negedge CLK);

    // Default period 50, OR
    step(0, 0, 0, 0, 8, 1, rd);     chk("t1_status_rst", 32'(rd), 32'h00);
    step(0, 0, 0, 0, 12, 1, rd);    chk("t1_period_rst", 32'(rd), 32'd50);
    step(1, 0, 8'h0F, 0, 8, 1, rd);
    step(1, 1, 8'hF0, 0, 8, 1, rd);
    n = 4;
    while (n < 70 && fire !== 1'b1) begin
      step(0, 0, 0, 0, 8, 1, rd);
      n++;
    end
    chk("t1_fire_cycle", 32'(n), 32'd51);
    step(0, 0, 0, 0, 8, 1, rd);     chk("t1_status", 32'(rd), 32'h01);
    step(0, 0, 0, 1, 9, 1, rd);     chk("t1_out", 32'(rd), 32'hFF);

    // Period 0, ADD
    step(1, 9, 8'd0, 0, 8, 1, rd);
    step(1, 8, 8'd3, 0, 8, 1, rd);
    step(1, 0, 8'hC8, 0, 8, 1, rd);
    step(1, 1, 8'h64, 0, 8, 1, rd);
    step(0, 0, 0, 0, 8, 1, rd);     chk("t2_fire", 32'(fire), 32'd1);
    step(0, 0, 0, 0, 9, 1, rd);     chk("t2_out", 32'(rd), 32'h2C);
    step(0, 0, 0, 0, 11, 1, rd);    chk("t2_level1", 32'(rd), 32'd1);
    step(0, 0, 0, 1, 9, 1, rd);
    step(0, 0, 0, 0, 11, 1, rd);    chk("t2_level0", 32'(rd), 32'd0);

    // Overfill ch0 with ch1 empty
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 8'($urandom), 0, 8, 1, rd);
    step(0, 0, 0, 0, 10, 1, rd);    chk("t3_drops", 32'(rd), 32'd1);
    chk("t3_nofire", 32'(fire), 32'd0);
    step(1, 10, 8'd0, 0, 8, 1, rd);
    step(0, 0, 0, 0, 10, 1, rd);    chk("t3_clr", 32'(rd), 32'd0);
    step(1, 1, 8'($urandom), 0, 8, 1, rd);
    step(1, 1, 8'($urandom), 0, 8, 1, rd);
    drain();

    // Output full backpressure, OR
    step(1, 8, 8'd0, 0, 8, 1, rd);
    nf = 0;
    for (int p = 0; p < 5; p++) begin
      step(1, 0, 8'($urandom), 0, 8, 1, rd); if (fire) nf++;
      step(1, 1, 8'($urandom), 0, 8, 1, rd); if (fire) nf++;
    end
    step(0, 0, 0, 0, 8, 1, rd);     if (fire) nf++;
    chk("t4_status", 32'(rd), 32'h07);
    chk("t4_nfires", 32'(nf), 32'd4);
    step(0, 0, 0, 0, 11, 1, rd);    chk("t4_level", 32'(rd), 32'd4);
    step(0, 0, 0, 1, 9, 1, rd);     chk("t4_pop_nofire", 32'(fire), 32'd0);
    step(0, 0, 0, 0, 8, 1, rd);     chk("t4_next_fire", 32'(fire), 32'd1);
    drain();

    // XOR, period 3: fires every 4 cycles
    step(1, 8, 8'd2, 0, 8, 1, rd);
    step(1, 9, 8'd3, 0, 8, 1, rd);
    nf = 0; last = -1;
    for (int k = 0; k < 32; k++) begin
      step(1, 4'(k % 2), 8'($urandom), 1, 9, 1, rd);
      if (fire) begin
        if (last >= 0) chk("t5_spacing", 32'(k - last), 32'd4);
        last = k; nf++;
      end
    end
    chk("t5_enough_fires", 32'(nf >= 6), 32'd1);

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 2) == 0) wa = 4'($urandom_range(8, 15));
      else wa = 4'($urandom_range(0, NCH - 1));
      wd = (wa == 4'd9) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      step(1'($urandom), wa, wd, 1'($urandom), 4'($urandom_range(0, 15)), 1, rd);
    end

    // Reset with data everywhere
    step(0, 0, 0, 0, 8, 0, rd);
    step(1, 9, 8'd0, 0, 8, 1, rd);
    step(1, 0, 8'h11, 0, 8, 1, rd);
    step(1, 1, 8'h22, 0, 8, 1, rd);
    step(1, 9, 8'd200, 0, 8, 1, rd);
    step(1, 0, 8'h33, 0, 8, 1, rd);
    step(1, 1, 8'h44, 0, 8, 1, rd);
    step(1, 0, 8'h55, 0, 8, 1, rd);
    step(1, 0, 8'h66, 0, 8, 1, rd);
    step(0, 0, 0, 0, 10, 1, rd);    chk("t6_drops_pre", 32'(rd), 32'd1);
    step(0, 0, 0, 0, 8, 1, rd);     chk("t6_status_pre", 32'(rd), 32'h05);
    step(0, 0, 0, 0, 8, 0, rd);
    step(0, 0, 0, 0, 8, 1, rd);     chk("t6_status", 32'(rd), 32'h00);
    step(0, 0, 0, 0, 10, 1, rd);    chk("t6_drops", 32'(rd), 32'd0);
    step(0, 0, 0, 0, 12, 1, rd);    chk("t6_period", 32'(rd), 32'd50);
    step(0, 0, 0, 0, 0, 1, rd);     chk("t6_ch0", 32'(rd), 32'h00);
    step(0, 0, 0, 0, 1, 1, rd);     chk("t6_ch1", 32'(rd), 32'h00);
    step(0, 0, 0, 0, 11, 1, rd);    chk("t6_level", 32'(rd), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
